// File: rtl/timer_pkg.sv
// Shared definitions for the timer sequencer: FSM state encodings and
// the table index / length width helpers.
package timer_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] ABORT  = 2'd3;

  // Width of a table index; never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width able to hold a sequence length of 0..depth inclusive.
  function automatic int len_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/timer_seq_table.sv
// Interval table: DEPTH x WIDTH registers, one synchronous write port and
// one asynchronous read port, cleared on reset.
module timer_seq_table
  import timer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = idx_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: this table is small and must read back as zero after reset, so it is
  // built from resettable flops; a large RAM would normally not be reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples
      // the pre-edge values, which also makes same-cycle reads see old data.
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en_i && (wr_addr_i == AW'(i))) mem[i] <= wr_data_i;
      end
    end
  end

  // Out-of-range addresses match no entry, so they write nothing and read 0.
  always_comb begin
    // NOTE: assign a default before any conditional so no latch is inferred.
    rd_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_i == AW'(i)) rd_data_o = mem[i];
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// Walks a programmable interval table, issuing start/count pairs to the
// countdown timer and reporting each expired step; supports loop and abort.
module timer_sequencer
  import timer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = idx_width(DEPTH),
  localparam int LW = len_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             run_i,
  input  logic [LW-1:0]    len_i,
  input  logic             loop_i,
  input  logic             abort_i,
  output logic             tmr_start_o,
  output logic [WIDTH-1:0] tmr_count_o,
  input  logic             tmr_done_i,
  output logic             busy_o,
  output logic             step_o,
  output logic [AW-1:0]    step_idx_o,
  output logic             seq_done_o
);

  logic [1:0]       state_q;
  logic [AW-1:0]    idx_q;
  logic [LW-1:0]    len_q;
  logic             loop_q;
  logic [WIDTH-1:0] count_q;
  logic             step_q;
  logic [AW-1:0]    step_idx_q;
  logic             seq_done_q;

  logic [LW-1:0]    len_clamped;
  logic             last;
  logic [AW-1:0]    idx_next;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;

  timer_seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign len_clamped = (len_i > LW'(DEPTH)) ? LW'(DEPTH) : len_i;
  assign last        = (LW'(idx_q) == (len_q - LW'(1)));
  assign idx_next    = last ? '0 : idx_q + AW'(1);
  // The table is read for the entry about to be launched: 0 from IDLE.
  assign rd_addr     = (state_q == WAIT) ? idx_next : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      count_q    <= '0;
      step_q     <= 1'b0;
      step_idx_q <= '0;
      seq_done_q <= 1'b0;
    end else begin
      step_q     <= 1'b0;
      seq_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run_i) begin
            if (len_clamped != '0) begin
              len_q   <= len_clamped;
              loop_q  <= loop_i;
              idx_q   <= '0;
              count_q <= rd_data;
              state_q <= LAUNCH;
            end else begin
              seq_done_q <= 1'b1;
            end
          end
        end
        // Done is not looked at here: the timer has not yet seen this count.
        LAUNCH: begin
          if (abort_i) begin
            count_q <= '0;
            state_q <= ABORT;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (abort_i) begin
            count_q <= '0;
            state_q <= ABORT;
          end else if (tmr_done_i) begin
            step_q     <= 1'b1;
            step_idx_q <= idx_q;
            if (last && !loop_q) begin
              seq_done_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              idx_q   <= idx_next;
              count_q <= rd_data;
              state_q <= LAUNCH;
            end
          end
        end
        ABORT:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tmr_start_o = (state_q == LAUNCH) || (state_q == ABORT);
  assign busy_o      = (state_q == LAUNCH) || (state_q == WAIT);
  assign tmr_count_o = count_q;
  assign step_o      = step_q;
  assign step_idx_o  = step_idx_q;
  assign seq_done_o  = seq_done_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer with a countdown timer model and
// scoreboards of expected launches and steps.
module tb_timer_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int LW    = 3;

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic             wr_en_i = 1'b0;
  logic [AW-1:0]    wr_addr_i = '0;
  logic [WIDTH-1:0] wr_data_i = '0;
  logic             run_i = 1'b0;
  logic [LW-1:0]    len_i = '0;
  logic             loop_i = 1'b0;
  logic             abort_i = 1'b0;
  logic             tmr_start_o;
  logic [WIDTH-1:0] tmr_count_o;
  logic             tmr_done_i;
  logic             busy_o;
  logic             step_o;
  logic [AW-1:0]    step_idx_o;
  logic             seq_done_o;

  always #5 clk_i = ~clk_i;

  timer_sequencer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .run_i       (run_i),
    .len_i       (len_i),
    .loop_i      (loop_i),
    .abort_i     (abort_i),
    .tmr_start_o (tmr_start_o),
    .tmr_count_o (tmr_count_o),
    .tmr_done_i  (tmr_done_i),
    .busy_o      (busy_o),
    .step_o      (step_o),
    .step_idx_o  (step_idx_o),
    .seq_done_o  (seq_done_o)
  );

  // Countdown timer model: loads on start, done while the count sits at zero.
  logic [WIDTH-1:0] t_cnt;
  logic             t_act;
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      t_cnt <= '0;
      t_act <= 1'b0;
    end else if (tmr_start_o) begin
      t_cnt <= tmr_count_o;
      t_act <= 1'b1;
    end else if (t_act) begin
      if (t_cnt == '0) t_act <= 1'b0;
      else             t_cnt <= t_cnt - 1'b1;
    end
  end
  assign tmr_done_i = t_act && (t_cnt == '0);

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int            cyc;
    logic          st;
    logic          dn;
    logic [AW-1:0] idx;
  } ev_t;

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] cnt;
  } ln_t;

  ev_t ev_q[$];
  ln_t ln_q[$];
  int  tbl[DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every launch and every step/seq_done event is matched.
  always @(negedge clk_i) begin
    ln_t l;
    ev_t e;
    if (rst_n_i) begin
      if (tmr_start_o) begin
        check("launch_expected", 64'(ln_q.size() != 0), 64'd1);
        if (ln_q.size() != 0) begin
          l = ln_q.pop_front();
          check("launch_cycle", 64'(cyc), 64'(l.cyc));
          check("launch_count", 64'(tmr_count_o), 64'(l.cnt));
        end
      end
      if (step_o || seq_done_o) begin
        check("event_expected", 64'(ev_q.size() != 0), 64'd1);
        if (ev_q.size() != 0) begin
          e = ev_q.pop_front();
          check("event_cycle", 64'(cyc), 64'(e.cyc));
          check("event_kind", 64'({step_o, seq_done_o}), 64'({e.st, e.dn}));
          check("event_idx", 64'(step_o ? step_idx_o : '0), 64'(e.idx));
        end
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk_i);
  endtask

  task automatic write_entry(input int a, input int d);
    wr_en_i   = 1'b1;
    wr_addr_i = AW'(a);
    wr_data_i = WIDTH'(d);
    @(negedge clk_i);
    wr_en_i = 1'b0;
    tbl[a]  = d;
  endtask

  // Expected schedule: an entry launched at t with value N steps at t+N+2,
  // and the following launch coincides with that step.
  task automatic sched(input int t0, input int i0, input int len, input bit lp,
                       input int n, output int nt, output int ni);
    int  t    = t0;
    int  i    = i0;
    int  leff = (len > DEPTH) ? DEPTH : len;
    int  s;
    bit  last;
    for (int k = 0; k < n; k++) begin
      ln_q.push_back(ln_t'{cyc: t, cnt: WIDTH'(tbl[i])});
      s    = t + tbl[i] + 2;
      last = (i == leff - 1);
      ev_q.push_back(ev_t'{cyc: s, st: 1'b1, dn: (last && !lp), idx: AW'(i)});
      t = s;
      i = last ? 0 : i + 1;
    end
    nt = t;
    ni = i;
  endtask

  task automatic run_seq(input int len, input bit lp, input int n,
                         output int t, output int nt, output int ni);
    t = cyc + 1;
    sched(t, 0, len, lp, n, nt, ni);
    run_i  = 1'b1;
    len_i  = LW'(len);
    loop_i = lp;
    @(negedge clk_i);
    run_i  = 1'b0;
    len_i  = '0;
    loop_i = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_start"}, 64'(tmr_start_o), 64'd0);
    check({tag, "_count"}, 64'(tmr_count_o), 64'd0);
    check({tag, "_busy"},  64'(busy_o),      64'd0);
    check({tag, "_step"},  64'(step_o),      64'd0);
    check({tag, "_idx"},   64'(step_idx_o),  64'd0);
    check({tag, "_done"},  64'(seq_done_o),  64'd0);
  endtask

  task automatic end_scn(input string tag);
    check({tag, "_events_left"},   64'(ev_q.size()), 64'd0);
    check({tag, "_launches_left"}, 64'(ln_q.size()), 64'd0);
    check({tag, "_idle"},          64'(busy_o),      64'd0);
    ev_q.delete();
    ln_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, nt, ni, c;
    for (int i = 0; i < DEPTH; i++) tbl[i] = 0;

    repeat (2) @(negedge clk_i);
    check_zero("reset");
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // One-shot sequence of three entries from table {3,0,5,1}.
    write_entry(0, 3);
    write_entry(1, 0);
    write_entry(2, 5);
    write_entry(3, 1);
    run_seq(3, 1'b0, 3, t, nt, ni);
    goto(t + 1);
    check("s1_busy_early", 64'(busy_o), 64'd1);
    goto(t + 13);
    check("s1_busy_last_wait", 64'(busy_o), 64'd1);
    goto(t + 14);
    check("s1_busy_at_done", 64'(busy_o), 64'd0);
    goto(t + 16);
    end_scn("s1");

    // Looping pair, then abort in the middle of a WAIT.
    run_seq(2, 1'b1, 4, t, nt, ni);
    ln_q.push_back(ln_t'{cyc: nt, cnt: WIDTH'(tbl[ni])});
    goto(t + 16);
    check("s2_busy_loop", 64'(busy_o), 64'd1);
    ln_q.push_back(ln_t'{cyc: t + 17, cnt: '0});
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    goto(t + 26);
    end_scn("s2");

    // Zero-length run: seq_done only.
    c = cyc;
    ev_q.push_back(ev_t'{cyc: c + 1, st: 1'b0, dn: 1'b1, idx: '0});
    run_i = 1'b1;
    len_i = '0;
    @(negedge clk_i);
    run_i = 1'b0;
    check("s3_not_busy", 64'(busy_o), 64'd0);
    goto(c + 5);
    end_scn("s3");

    // Rewrite entry 1 while it is in flight; only its next launch sees 7.
    run_seq(2, 1'b1, 2, t, nt, ni);
    goto(t + 6);
    wr_en_i   = 1'b1;
    wr_addr_i = AW'(1);
    wr_data_i = WIDTH'(7);
    tbl[1]    = 7;
    sched(nt, ni, 2, 1'b1, 2, nt, ni);
    ln_q.push_back(ln_t'{cyc: nt, cnt: WIDTH'(tbl[ni])});
    @(negedge clk_i);
    wr_en_i = 1'b0;
    goto(nt + 1);
    ln_q.push_back(ln_t'{cyc: nt + 2, cnt: '0});
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    goto(nt + 8);
    end_scn("s4");

    // Abort in the very cycle the timer reports done: no step.
    ln_q.push_back(ln_t'{cyc: cyc + 1, cnt: WIDTH'(tbl[0])});
    run_seq(1, 1'b1, 0, t, nt, ni);
    goto(t + 4);
    ln_q.push_back(ln_t'{cyc: t + 5, cnt: '0});
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    goto(t + 10);
    end_scn("s5a");

    // run_i while busy is ignored.
    run_seq(1, 1'b0, 1, t, nt, ni);
    goto(t + 2);
    run_i = 1'b1;
    len_i = '0;
    @(negedge clk_i);
    run_i = 1'b0;
    goto(t + 8);
    end_scn("s5b");

    // Asynchronous reset mid-WAIT, then a one-entry run from the cleared table.
    ln_q.push_back(ln_t'{cyc: cyc + 1, cnt: WIDTH'(tbl[0])});
    run_seq(1, 1'b0, 0, t, nt, ni);
    goto(t + 2);
    #1 rst_n_i = 1'b0;
    #1 check_zero("async_reset");
    ev_q.delete();
    ln_q.delete();
    for (int i = 0; i < DEPTH; i++) tbl[i] = 0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    run_seq(1, 1'b0, 1, t, nt, ni);
    goto(t + 4);
    end_scn("s6");

    // Over-long length is clamped to the table depth.
    write_entry(0, 2);
    write_entry(1, 1);
    write_entry(2, 0);
    write_entry(3, 4);
    run_seq(7, 1'b0, 4, t, nt, ni);
    goto(t + 18);
    end_scn("s7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
Upstream controller for the team's countdown `timer` block. Holds a small programmable table of intervals and walks through it in order. For each entry it issues a start/count pair to the timer, waits for the timer's done, then signals the step. It supports one-shot or looping sequences and abort, turning a single countdown into a multi-phase schedule.

Parameters:
WIDTH, 8, width of each interval entry and of tmr_count_o
DEPTH, 4, number of table entries (>=2); AW = $clog2(DEPTH), LW = $clog2(DEPTH+1)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset; one clock, reset is asynchronous and active-low
wr_en_i  in  1  table write strobe
wr_addr_i  in  AW  table write index
wr_data_i  in  WIDTH  interval value written
run_i  in  1  start-sequence pulse
len_i  in  LW  number of entries to run (0..DEPTH), sampled on accepted run_i
loop_i  in  1  repeat forever when 1, sampled on accepted run_i
abort_i  in  1  stop the sequence and cancel the timer
tmr_start_o  out  1  to timer start input
tmr_count_o  out  WIDTH  to timer count input
tmr_done_i  in  1  from timer done output
busy_o  out  1  sequence active
step_o  out  1  one-cycle pulse when an entry's interval has expired
step_idx_o  out  AW  index of the entry just completed (valid with step_o)
seq_done_o  out  1  one-cycle pulse when a non-looping sequence finishes

Behaviour:
- Reset (async, rst_n_i=0):
  - state=IDLE; all table entries=0.
  - All outputs 0, including tmr_count_o and step_idx_o.
  - The integrator resets the timer in the same reset window.
- States: IDLE, LAUNCH, WAIT, ABORT. Encoding is 2-bit; state is registered.
- tmr_start_o=1 only in LAUNCH or ABORT. tmr_count_o is a register: table[idx] in LAUNCH, 0 in ABORT.
- busy_o=1 in LAUNCH or WAIT.
- IDLE:
  - run_i=1 and len_i>0: capture len and loop, idx=0, load count_q=table[0], go to LAUNCH.
  - run_i=1 and len_i=0: no launch; seq_done_o pulses next cycle; stay IDLE.
  - len_i>DEPTH is clamped to DEPTH.
- LAUNCH: lasts exactly 1 cycle, then WAIT. tmr_done_i is ignored here because it reflects the previous count.
- WAIT, on tmr_done_i=1:
  - step_o=1 and step_idx_o=idx in the next cycle (registered).
  - If idx==len-1 and !loop: go to IDLE, with seq_done_o=1 in the same cycle as that step_o.
  - Otherwise: idx wraps to 0 after len-1 (loop), else increments; count_q=table[new idx]; go to LAUNCH.
- Timing: if LAUNCH is in cycle t with entry value N, step_o occurs in cycle t+N+2. Step-to-step period is N+2; N=0 gives period 2.
- Abort:
  - abort_i in LAUNCH or WAIT goes to ABORT: one cycle with tmr_start_o=1 and count 0, which cancels the timer. Then IDLE.
  - No step_o or seq_done_o is produced for the aborted entry.
  - abort_i in IDLE or ABORT is ignored.
- Simultaneous events:
  - abort_i takes priority over tmr_done_i and run_i.
  - run_i while busy is ignored; it does not restart.
- Table writes:
  - Accepted in any state; wr_addr_i>=DEPTH is ignored.
  - count_q is captured at the transition into LAUNCH, so a write to the in-flight entry affects only its next launch.
  - A write and a read of the same index in the same cycle return the old value.
- Arithmetic: idx and len are unsigned; no overflow beyond the clamp. Entry value 0 is legal.

Decomposition:
- Shared package/include timer_pkg: state localparams (IDLE=0, LAUNCH=1, WAIT=2, ABORT=3) and the AW/LW width helper.
- Sub-module timer_seq_table: DEPTH x WIDTH register file with one sync write port and one async read port, cleared on rst_n_i.
- The FSM and output registers live in timer_sequencer.

Test Plan:
1. Table {3,0,5,1}, run_i with len=3, loop=0, timer attached:
   - LAUNCH at cycles t, t+5, t+7.
   - step_o at t+5, t+7, t+14 with idx 0, 1, 2.
   - seq_done_o at t+14; busy_o low at t+14.
2. Same table, len=2, loop=1:
   - step_idx_o sequence 0,1,0,1,... with periods 5,2,5,2.
   - seq_done_o never asserted.
   - abort_i mid-WAIT gives one tmr_start_o pulse with count 0, then IDLE, with no further step_o.
3. run_i with len=0 → seq_done_o pulses one cycle later; tmr_start_o never asserted.
4. During WAIT on entry 1, write entry 1=7 → current step timing unchanged; the next loop iteration's launch of entry 1 drives tmr_count_o=7.
5. Simultaneous events:
   - abort_i and tmr_done_i in the same cycle → ABORT taken, no step_o.
   - run_i while busy → no effect.
6. rst_n_i dropped asynchronously mid-WAIT → all outputs 0 immediately, with no clock edge needed. After release, a table read gives 0 and run_i with len=1 steps after 2 cycles.
